// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch/next-PC logic.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } seq_state_e;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_src_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

   // Register jump beats jump beats taken branch beats fall-through.
   function automatic npc_src_e npc_select(input logic br_taken, input logic is_j,
                                           input logic is_jr);
      if (is_jr)         return NPC_JR;
      else if (is_j)     return NPC_J;
      else if (br_taken) return NPC_BR;
      else               return NPC_SEQ;
   endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC mux: sequential, branch, jump-merge and register targets.
module npc_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [25:0] instr_idx,
   input  logic [15:0] br_off,
   input  npc_src_e    sel,
   input  logic [31:0] jr_target,
   output logic [31:0] npc,
   output logic        misaligned
);

   logic [31:0] pc_plus4;
   logic [31:0] br_target;

   always_comb begin
      pc_plus4  = pc + 32'd4;
      br_target = pc_plus4 + {{14{br_off[15]}}, br_off, 2'b00};
      case (sel)
         NPC_BR:  npc = br_target;
         NPC_J:   npc = {pc[31:26], instr_idx};
         NPC_JR:  npc = jr_target;
         default: npc = pc_plus4;
      endcase
      misaligned = |npc[1:0];
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/next-PC controller: owns the PC, runs the imem handshake, holds the
// instruction until retire and counts retired instructions.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | out of reset, one cycle before the first fetch
//  ST_FETCH | imem_req high at pc, waiting for imem_ack
//  ST_EXEC  | instruction held for execute, waiting for ex_done or exc
//  ST_HALT  | stopped after a halting retire, left only by reset
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   input  logic        ex_done,
   input  logic        br_taken,
   input  logic [15:0] br_off,
   input  logic        is_j,
   input  logic        is_jr,
   input  logic [31:0] jr_target,
   input  logic        halt,
   input  logic        exc,
   output logic        adel,
   output logic [31:0] badaddr,
   output logic        halted,
   output logic [31:0] instret
);

   seq_state_e  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        adel_q, adel_d;
   logic [31:0] badaddr_q, badaddr_d;
   logic [31:0] instret_q, instret_d;
   logic        exc_pend_q, exc_pend_d;

   logic [31:0] npc;
   logic        npc_mis;

   npc_calc u_npc_calc (
      .pc         (pc_q),
      .instr_idx  (instr_q[25:0]),
      .br_off     (br_off),
      .sel        (npc_select(br_taken, is_j, is_jr)),
      .jr_target  (jr_target),
      .npc        (npc),
      .misaligned (npc_mis)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_out_d   = pc_out_q;
      adel_d     = 1'b0;
      badaddr_d  = badaddr_q;
      instret_d  = instret_q;
      exc_pend_d = exc_pend_q;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            if (imem_ack) begin
               // An exception seen at any point during the fetch drops the data.
               if (exc_pend_q || exc) begin
                  pc_d       = EXC_VEC;
                  exc_pend_d = 1'b0;
               end else begin
                  instr_d  = imem_rdata;
                  pc_out_d = pc_q;
                  state_d  = ST_EXEC;
               end
            end else if (exc) begin
               exc_pend_d = 1'b1;
            end
         end
         ST_EXEC: begin
            if (exc) begin
               pc_d    = EXC_VEC;
               state_d = ST_FETCH;
            end else if (ex_done) begin
               instret_d = instret_q + 32'd1;
               if (npc_mis) begin
                  pc_d      = EXC_VEC;
                  badaddr_d = npc;
                  adel_d    = 1'b1;
               end else begin
                  pc_d = npc;
               end
               state_d = halt ? ST_HALT : ST_FETCH;
            end
         end
         default: state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         pc_out_q   <= '0;
         adel_q     <= 1'b0;
         badaddr_q  <= '0;
         instret_q  <= '0;
         exc_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_out_q   <= pc_out_d;
         adel_q     <= adel_d;
         badaddr_q  <= badaddr_d;
         instret_q  <= instret_d;
         exc_pend_q <= exc_pend_d;
      end
   end

   assign imem_req    = (state_q == ST_FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == ST_EXEC);
   assign halted      = (state_q == ST_HALT);
   assign instr_out   = instr_q;
   assign pc_out      = pc_out_q;
   assign adel        = adel_q;
   assign badaddr     = badaddr_q;
   assign instret     = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed cases plus randomized
// fetch/execute traffic against an instruction-level reference model.
module tb_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EV     = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        ex_done;
   logic        br_taken;
   logic [15:0] br_off;
   logic        is_j;
   logic        is_jr;
   logic [31:0] jr_target;
   logic        halt;
   logic        exc;
   logic        adel;
   logic [31:0] badaddr;
   logic        halted;
   logic [31:0] instret;

   pc_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_out   (instr_out),
      .pc_out      (pc_out),
      .ex_done     (ex_done),
      .br_taken    (br_taken),
      .br_off      (br_off),
      .is_j        (is_j),
      .is_jr       (is_jr),
      .jr_target   (jr_target),
      .halt        (halt),
      .exc         (exc),
      .adel        (adel),
      .badaddr     (badaddr),
      .halted      (halted),
      .instret     (instret)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   // Instruction-level model of the architectural state.
   logic [31:0] m_pc, m_instr, m_badaddr, m_instret;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req"},     {31'd0, imem_req},    32'd0);
      chk({tag, "_addr"},    imem_addr,            RST_PC);
      chk({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
      chk({tag, "_instr"},   instr_out,            32'd0);
      chk({tag, "_pcout"},   pc_out,               32'd0);
      chk({tag, "_adel"},    {31'd0, adel},        32'd0);
      chk({tag, "_badaddr"}, badaddr,              32'd0);
      chk({tag, "_halted"},  {31'd0, halted},      32'd0);
      chk({tag, "_instret"}, instret,              32'd0);
      m_pc = RST_PC; m_instr = '0; m_badaddr = '0; m_instret = '0;
   endtask

   task automatic clear_ctrl();
      imem_ack = 0; ex_done = 0; exc = 0; halt = 0;
      br_taken = 0; is_j = 0; is_jr = 0; br_off = '0; jr_target = '0;
   endtask

   // Called at a negedge with the DUT in FETCH. exc_cyc<0 means no exception.
   task automatic fetch(input logic [31:0] data, input int wait_cyc, input int exc_cyc);
      for (int i = 0; i <= wait_cyc; i++) begin
         chk("f_req",   {31'd0, imem_req},    32'd1);
         chk("f_addr",  imem_addr,            m_pc);
         chk("f_valid", {31'd0, instr_valid}, 32'd0);
         imem_ack   = (i == wait_cyc);
         imem_rdata = (i == wait_cyc) ? data : $urandom();
         exc        = (i == exc_cyc);
         @(negedge clk);
         if (i == 0) chk("adel_pulse", {31'd0, adel}, 32'd0);
      end
      imem_ack = 0;
      exc      = 0;
      if (exc_cyc >= 0 && exc_cyc <= wait_cyc) begin
         m_pc = EV;
         chk("fx_valid", {31'd0, instr_valid}, 32'd0);
         chk("fx_req",   {31'd0, imem_req},    32'd1);
         chk("fx_addr",  imem_addr,            EV);
      end else begin
         m_instr = data;
         chk("f_vld",   {31'd0, instr_valid}, 32'd1);
         chk("f_instr", instr_out,            data);
         chk("f_pcout", pc_out,               m_pc);
         chk("f_req0",  {31'd0, imem_req},    32'd0);
      end
   endtask

   // Called at a negedge with the DUT in EXEC; done or x must be set.
   task automatic exec(input int wait_cyc, input logic done, input logic x,
                       input logic bt, input logic [15:0] off, input logic j,
                       input logic jr, input logic [31:0] jt, input logic hl);
      logic [31:0] npc;
      logic        exp_adel, exp_halt;
      for (int i = 0; i < wait_cyc; i++) begin
         chk("e_valid", {31'd0, instr_valid}, 32'd1);
         ex_done = 0; exc = 0;
         br_taken = 1'($urandom()); is_j = 1'($urandom()); is_jr = 1'($urandom());
         br_off = 16'($urandom()); jr_target = $urandom(); halt = 1'($urandom());
         @(negedge clk);
      end
      chk("e_valid", {31'd0, instr_valid}, 32'd1);
      chk("e_pcout", pc_out, m_pc);
      ex_done = done; exc = x; br_taken = bt; br_off = off;
      is_j = j; is_jr = jr; jr_target = jt; halt = hl;
      @(negedge clk);
      clear_ctrl();
      exp_adel = 0;
      exp_halt = 0;
      if (x) begin
         m_pc = EV;
      end else begin
         if (jr)      npc = jt;
         else if (j)  npc = {m_pc[31:26], m_instr[25:0]};
         else if (bt) npc = m_pc + 32'd4 + 32'(int'($signed(off)) * 4);
         else         npc = m_pc + 32'd4;
         m_instret = m_instret + 1;
         if (npc % 4 != 0) begin
            m_badaddr = npc;
            m_pc      = EV;
            exp_adel  = 1;
         end else begin
            m_pc = npc;
         end
         exp_halt = hl;
      end
      chk("e_addr",    imem_addr,            m_pc);
      chk("e_instret", instret,              m_instret);
      chk("e_adel",    {31'd0, adel},        {31'd0, exp_adel});
      chk("e_badaddr", badaddr,              m_badaddr);
      chk("e_halted",  {31'd0, halted},      {31'd0, exp_halt});
      chk("e_req",     {31'd0, imem_req},    {31'd0, !exp_halt});
      chk("e_valid0",  {31'd0, instr_valid}, 32'd0);
   endtask

   initial begin
      int fw, fx, ew;
      logic x, d, jr, j, bt;
      logic [31:0] jt;

      rst_n = 0;
      imem_rdata = '0;
      clear_ctrl();
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1;
      @(negedge clk);

      // Startup, zero-wait fetch, sequential retire.
      fetch(32'h2000_0000, 0, -1);
      exec(0, 1, 0, 0, 16'h0, 0, 0, 32'h0, 0);

      // Branch back to itself and branch wrap.
      fetch($urandom(), 1, -1);
      exec(1, 1, 0, 0, 16'h0, 0, 1, 32'h0000_3000, 0);
      fetch($urandom(), 0, -1);
      exec(0, 1, 0, 1, 16'hFFFF, 0, 0, 32'h0, 0);
      fetch($urandom(), 0, -1);
      exec(0, 1, 0, 0, 16'h0, 0, 1, 32'hFFFF_FFF0, 0);
      fetch($urandom(), 2, -1);
      exec(2, 1, 0, 1, 16'h7FFF, 0, 0, 32'h0, 0);

      // Jump merge, aligned and misaligned.
      fetch($urandom(), 0, -1);
      exec(0, 1, 0, 0, 16'h0, 0, 1, 32'h0000_3004, 0);
      fetch(32'h0000_0C10, 0, -1);
      exec(0, 1, 0, 0, 16'h0, 1, 0, 32'h0, 0);
      fetch($urandom(), 0, -1);
      exec(0, 1, 0, 0, 16'h0, 0, 1, 32'h0000_3004, 0);
      fetch(32'h0000_0C11, 0, -1);
      exec(0, 1, 0, 0, 16'h0, 1, 0, 32'h0, 0);

      // Register jump has priority over jump and branch.
      fetch($urandom(), 0, -1);
      exec(0, 1, 0, 1, 16'h0010, 1, 1, 32'h0000_3100, 0);

      // Exception during fetch, then exception with retire and halt.
      fetch($urandom(), 3, 0);
      fetch($urandom(), 0, -1);
      exec(1, 1, 1, 0, 16'h0, 0, 0, 32'h0, 1);

      for (int k = 0; k < 150; k++) begin
         fw = int'($urandom_range(0, 3));
         fx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, fw)) : -1;
         fetch($urandom(), fw, fx);
         if (fx >= 0) continue;
         ew = int'($urandom_range(0, 3));
         x  = ($urandom_range(0, 9) == 0);
         d  = x ? 1'($urandom()) : 1'b1;
         jr = ($urandom_range(0, 5) == 0);
         j  = ($urandom_range(0, 3) == 0);
         bt = 1'($urandom());
         jt = $urandom() & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         exec(ew, d, x, bt, 16'($urandom()), j, jr, jt, 0);
      end

      // Halt: stays stopped despite exceptions and stray acks.
      fetch($urandom(), 1, -1);
      exec(0, 1, 0, 0, 16'h0, 0, 0, 32'h0, 1);
      for (int i = 0; i < 12; i++) begin
         chk("h_halted", {31'd0, halted},      32'd1);
         chk("h_req",    {31'd0, imem_req},    32'd0);
         chk("h_valid",  {31'd0, instr_valid}, 32'd0);
         exc      = 1'($urandom());
         imem_ack = 1'($urandom());
         @(negedge clk);
      end
      clear_ctrl();
      chk("h_instret", instret, m_instret);

      // Reset asserted in the middle of a fetch.
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("r_req", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      #2 rst_n = 0;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
